// File: rtl/bluetile_pkg.sv
// bluetile_pkg: shared word type, header length field and arbiter states for bluetile request arbiters
package bluetile_pkg;
    localparam int BT_WORD_W  = 32;
    localparam int BT_LEN_MSB = 7;
    localparam int BT_LEN_LSB = 0;
    typedef logic [BT_WORD_W-1:0] bt_word_t;
    typedef enum logic [1:0] {IDLE, HEAD, BODY} arb_state_t;
endpackage

// File: rtl/bluetile_request_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first set request strictly after ptr, wrapping
//   req     in  N   request vector
//   ptr     in  GW  last served index; search starts at ptr+1
//   winner  out GW  chosen index (0 when nothing requests)
//   any_req out 1   at least one request is set
module rr_pick #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [GW-1:0] winner,
    output logic          any_req
);
    logic [GW-1:0] idx;
    // Scan from farthest to nearest so the nearest requester after ptr is the last write
    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = |req;
        for (int k = N; k >= 1; k--) begin
            idx = GW'((int'(ptr) + k) % N);
            if (req[idx]) winner = idx;
        end
    end
endmodule

// File: rtl/bluetile_request_arbiter.sv
// bluetile_request_arbiter: packet-atomic round-robin share of one bluetile request port among on-tile clients
//   CLK, RST_N               clock and asynchronous active-low reset
//   client_request_DOUT      in  NUM_CLIENTS*32  client i word at [32i+31:32i]
//   client_request_valid     in  NUM_CLIENTS     client i has a word
//   client_request_accept    out NUM_CLIENTS     client i word taken this cycle
//   bluetile_request_DOUT    out 32              word to network (0 when idle)
//   bluetile_request_valid   out 1               word present
//   bluetile_request_accept  in  1               network takes word
//   grant_id                 out GW              current owner, held after packet end
//   busy                     out 1               packet in progress
module bluetile_request_arbiter
    import bluetile_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int GW          = $clog2(NUM_CLIENTS)
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic [NUM_CLIENTS*BT_WORD_W-1:0] client_request_DOUT,
    input  logic [NUM_CLIENTS-1:0]           client_request_valid,
    output logic [NUM_CLIENTS-1:0]           client_request_accept,
    output bt_word_t                         bluetile_request_DOUT,
    output logic                             bluetile_request_valid,
    input  logic                             bluetile_request_accept,
    output logic [GW-1:0]                    grant_id,
    output logic                             busy
);
    arb_state_t    state, state_nxt;
    logic [7:0]    cnt;
    logic [GW-1:0] rr_ptr, winner;
    logic          any_req, hs, last;
    bt_word_t      words [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_words
        assign words[i] = client_request_DOUT[i*BT_WORD_W +: BT_WORD_W];
    end

    rr_pick #(.N(NUM_CLIENTS), .GW(GW)) u_pick (
        .req     (client_request_valid),
        .ptr     (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Owner's signals pass straight through while a packet is open
    assign busy                   = state != IDLE;
    assign bluetile_request_valid = busy && client_request_valid[grant_id];
    assign bluetile_request_DOUT  = busy ? words[grant_id] : '0;
    assign client_request_accept  = busy ? (NUM_CLIENTS'(bluetile_request_accept) << grant_id) : '0;
    assign hs   = bluetile_request_valid && bluetile_request_accept;
    // Final word: a zero-length header, or the body word that brings cnt from 1 to 0
    assign last = (state == HEAD) ? (bluetile_request_DOUT[BT_LEN_MSB:BT_LEN_LSB] == 8'd0) : (cnt == 8'd1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = HEAD;
            HEAD:    if (hs) state_nxt = last ? IDLE : BODY;
            BODY:    if (hs && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) state <= IDLE;
        else state <= state_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            grant_id <= '0;
            cnt      <= '0;
            rr_ptr   <= GW'(NUM_CLIENTS - 1);
        end else begin
            if (state == IDLE && any_req) grant_id <= winner;
            if (hs) begin
                cnt <= (state == HEAD) ? bluetile_request_DOUT[BT_LEN_MSB:BT_LEN_LSB] : cnt - 8'd1;
                if (last) rr_ptr <= grant_id;
            end
        end
    end
endmodule

// File: tb/tb_bluetile_request_arbiter.sv
// tb_bluetile_request_arbiter: randomized packet traffic checked against a packet-level round-robin model
module tb_bluetile_request_arbiter;
    localparam int N  = 4;
    localparam int GW = 2;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [N*32-1:0] cdout;
    logic [N-1:0]    cvalid, caccept;
    logic [31:0]     bdout;
    logic            bvalid, baccept;
    logic [GW-1:0]   gid;
    logic            busy;

    bluetile_request_arbiter #(.NUM_CLIENTS(N), .GW(GW)) dut (
        .CLK                     (CLK),
        .RST_N                   (RST_N),
        .client_request_DOUT     (cdout),
        .client_request_valid    (cvalid),
        .client_request_accept   (caccept),
        .bluetile_request_DOUT   (bdout),
        .bluetile_request_valid  (bvalid),
        .bluetile_request_accept (baccept),
        .grant_id                (gid),
        .busy                    (busy)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          fails = 0;
    int          hs_total = 0;
    int          vpct = 100;
    int          apct = 100;
    logic [31:0] cq [N][$];
    logic [31:0] expq [$];
    bit          m_idle = 1'b1;
    int          m_owner = 0;
    int          m_rr = N - 1;
    int          m_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packet-level owner/words-left tracking; pushes whole expected packets at grant time
    logic [31:0] m_hdr;
    int          m_c;
    always @(negedge CLK) begin
        if (!RST_N) begin
            m_idle = 1'b1;
            m_owner = 0;
            m_rr = N - 1;
            expq.delete();
        end else begin
            check("busy", 32'(busy), 32'(!m_idle));
            check("grant_id", 32'(gid), m_owner);
            check("bt_valid", 32'(bvalid), 32'(!m_idle && cvalid[m_owner]));
            check("client_accept", 32'(caccept), (!m_idle && baccept) ? (1 << m_owner) : 0);
            if (m_idle) begin
                check("idle_dout", bdout, 32'h0);
                if (|cvalid) begin
                    for (int k = 1; k <= N; k++) begin
                        m_c = (m_rr + k) % N;
                        if (cvalid[m_c]) break;
                    end
                    m_owner = m_c;
                    m_hdr = cq[m_owner][0];
                    m_left = 1 + int'(m_hdr[7:0]);
                    for (int j = 0; j < m_left; j++) expq.push_back(cq[m_owner][j]);
                    m_idle = 1'b0;
                end
            end else if (cvalid[m_owner] && baccept) begin
                m_left--;
                if (m_left == 0) begin
                    m_idle = 1'b1;
                    m_rr = m_owner;
                end
            end
        end
    end

    // Monitor: every network handshake must be the next expected word
    always @(negedge CLK) begin
        if (RST_N && bvalid && baccept) begin
            hs_total++;
            if (expq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL word: got %h expected no word", bdout);
            end else check("word", bdout, expq.pop_front());
        end
    end

    task automatic load(input int c, input int len);
        logic [31:0] h;
        h = $urandom();
        h[7:0] = 8'(len);
        cq[c].push_back(h);
        for (int j = 0; j < len; j++) cq[c].push_back($urandom());
    endtask

    task automatic step();
        logic [N-1:0] hsv;
        @(negedge CLK);
        hsv = caccept & cvalid;
        @(posedge CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hsv[i]) void'(cq[i].pop_front());
            if (cq[i].size() == 0) cvalid[i] = 1'b0;
            else if (!(cvalid[i] && !hsv[i])) cvalid[i] = ($urandom_range(99) < vpct);
            cdout[i*32 +: 32] = (cq[i].size() != 0) ? cq[i][0] : 32'h0;
        end
        baccept = ($urandom_range(99) < apct);
    endtask

    task automatic drain();
        int n;
        bit pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < 20000) begin
            step();
            n++;
            pending = !m_idle;
            for (int i = 0; i < N; i++) if (cq[i].size() != 0) pending = 1'b1;
        end
        if (n >= 20000) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d cycles expected fewer than 20000", n);
        end
        repeat (3) step();
    endtask

    initial begin
        int base, n;
        cvalid = '0;
        cdout = '0;
        baccept = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_accept", 32'(caccept), 32'h0);
        check("rst_valid", 32'(bvalid), 32'h0);
        check("rst_dout", bdout, 32'h0);
        check("rst_grant", 32'(gid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        RST_N = 1'b1;
        cq[2].push_back(32'h0102_0003);
        for (int j = 0; j < 3; j++) cq[2].push_back(32'hA000_0000 + j);
        drain();
        for (int p = 0; p < 2; p++) begin
            load(0, 1);
            load(1, 1);
        end
        drain();
        load(3, 0);
        drain();
        load(0, 1);
        load(3, 2);
        drain();
        vpct = 75;
        apct = 70;
        for (int p = 0; p < 40; p++) begin
            load($urandom_range(N - 1), $urandom_range(6));
            if (p == 20) load(0, 255);
        end
        drain();
        vpct = 100;
        apct = 100;
        load(1, 4);
        base = hs_total;
        n = 0;
        while (hs_total < base + 2 && n < 100) begin
            step();
            n++;
        end
        check("reset_point_words", hs_total - base, 2);
        RST_N = 1'b0;
        #1;
        check("abort_accept", 32'(caccept), 32'h0);
        check("abort_valid", 32'(bvalid), 32'h0);
        check("abort_dout", bdout, 32'h0);
        check("abort_grant", 32'(gid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        for (int i = 0; i < N; i++) cq[i].delete();
        cvalid = '0;
        cdout = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        load(3, 1);
        load(0, 2);
        load(1, 0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
